// File: rtl/dma_apb_cfg_master.sv
// APB initiator for the DMA configuration port, fed by a valid/ready command channel.
// One transfer in flight; APB phases advance only on pclken-qualified clk edges.
module dma_apb_cfg_master #(
  parameter int ADDR_BITS   = 13,
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_BITS    = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pclken,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [31:0]          cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic                 busy,
  output logic                 psel,
  output logic                 penable,
  output logic [ADDR_BITS-1:0] paddr,
  output logic                 pwrite,
  output logic [31:0]          pwdata,
  input  logic [31:0]          prdata,
  input  logic                 pslverr,
  input  logic                 pready
);

  typedef enum logic [2:0] {S_IDLE, S_PEND, S_SETUP, S_ACCESS, S_RESP} state_t;

  localparam logic [CNT_BITS-1:0] LP_CNT_LAST = CNT_BITS'(TIMEOUT_CYC - 1);
  localparam logic [CNT_BITS-1:0] LP_CNT_MAX  = '1;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_cmd_write;
  logic [ADDR_BITS-1:0] r_cmd_addr;
  logic [31:0]          r_cmd_wdata;
  logic                 r_pwrite;
  logic [ADDR_BITS-1:0] r_paddr;
  logic [31:0]          r_pwdata;
  logic [31:0]          r_rsp_rdata;
  logic                 r_rsp_err;
  logic                 r_rsp_timeout;
  logic [CNT_BITS-1:0]  r_cnt;
  logic                 w_accept;
  logic                 w_access_tick;
  logic                 w_done;
  logic                 w_abort;

  assign w_accept      = (r_state == S_IDLE) && cmd_valid;
  assign w_access_tick = (r_state == S_ACCESS) && pclken;
  assign w_done        = w_access_tick && pready;
  assign w_abort       = w_access_tick && !pready && (TIMEOUT_CYC != 0) && (r_cnt == LP_CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (cmd_valid)         w_state_next = S_PEND;
      S_PEND:   if (pclken)            w_state_next = S_SETUP;
      S_SETUP:  if (pclken)            w_state_next = S_ACCESS;
      S_ACCESS: if (w_done || w_abort) w_state_next = S_RESP;
      S_RESP:   if (rsp_ready)         w_state_next = S_IDLE;
      default:                         w_state_next = S_IDLE;
    endcase
  end

  // psel/penable decode straight from the state so a reset drops them at once
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    psel      = 1'b0;
    penable   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_SETUP:  psel = 1'b1;
      S_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      S_RESP:   rsp_valid = 1'b1;
      default:  busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd_write   <= 1'b0;
      r_cmd_addr    <= '0;
      r_cmd_wdata   <= '0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_cnt         <= '0;
    end else begin
      if (w_accept) begin
        r_cmd_write <= cmd_write;
        r_cmd_addr  <= cmd_addr & ~ADDR_BITS'(3);
        r_cmd_wdata <= cmd_wdata;
      end
      if ((r_state == S_PEND) && pclken) begin
        r_paddr  <= r_cmd_addr;
        r_pwrite <= r_cmd_write;
        r_pwdata <= r_cmd_write ? r_cmd_wdata : 32'h0;
      end
      if ((r_state == S_SETUP) && pclken) begin
        r_cnt <= '0;
      end
      if (w_done) begin
        r_rsp_rdata   <= r_pwrite ? 32'h0 : prdata;
        r_rsp_err     <= pslverr;
        r_rsp_timeout <= 1'b0;
      end else if (w_abort) begin
        r_rsp_rdata   <= 32'h0;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
      end else if (w_access_tick && (r_cnt != LP_CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign paddr       = r_paddr;
  assign pwrite      = r_pwrite;
  assign pwdata      = r_pwdata;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_dma_apb_cfg_master.sv
// Bench for dma_apb_cfg_master: directed vector table, reset-in-ACCESS sequence, and
// randomized transfers checked cycle by cycle against a pclken-edge-counting model.
module tb_dma_apb_cfg_master;

  localparam int AW = 13;
  localparam int TO = 8;
  localparam int CB = 4;
  localparam int NVEC = 8;
  localparam int NRAND = 40;

  logic          clk = 1'b0;
  logic          reset;
  logic          pclken;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          busy;
  logic          psel;
  logic          penable;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          pslverr;
  logic          pready;

  dma_apb_cfg_master #(.ADDR_BITS(AW), .TIMEOUT_CYC(TO), .CNT_BITS(CB)) dut (
    .clk(clk), .reset(reset), .pclken(pclken),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pslverr(pslverr), .pready(pready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic [31:0]   rd;
    logic          se;
    int            waits;  // pready-low ACCESS pclken edges before completion
    int            div;    // pclken every div-th clk; 0 = random pclken
    int            hold;   // clks rsp_ready stays low in RESP
    logic [31:0]   x_rdata;
    logic          x_err;
    logic          x_to;
  } vec_t;

  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  // Last values the APB address/data lines must hold until the next SETUP
  logic [AW-1:0] exp_paddr  = '0;
  logic          exp_pwrite = 1'b0;
  logic [31:0]   exp_pwdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ref_rsp(input vec_t v, output logic [31:0] x_rdata, output logic x_err,
                         output logic x_to);
    x_to    = (TO != 0) && (v.waits >= TO);
    x_err   = x_to || v.se;
    x_rdata = (v.wr || x_to) ? 32'h0 : v.rd;
  endtask

  task automatic run_xfer(input int id, input vec_t v);
    int n;
    int done;
    int held;
    bit finished;
    logic [AW-1:0] a_al;
    done = (v.waits >= TO) ? TO + 2 : 3 + v.waits;
    a_al = v.addr & ~AW'(3);
    $display("xfer %0d: %s addr=0x%03h wdata=0x%08h waits=%0d div=%0d hold=%0d -> rdata=0x%08h err=%0b timeout=%0b",
             id, v.wr ? "WR" : "RD", v.addr, v.wd, v.waits, v.div, v.hold, v.x_rdata, v.x_err, v.x_to);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wd;
    rsp_ready = 1'b0;
    pclken    = 1'($urandom);
    pready    = 1'($urandom);
    prdata    = $urandom;
    pslverr   = 1'($urandom);
    @(posedge clk); #1;
    n = 0;
    held = 0;
    finished = 0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (n >= 1) begin
        exp_paddr  = a_al;
        exp_pwrite = v.wr;
        exp_pwdata = v.wr ? v.wd : 32'h0;
      end
      check("ctrl", 64'({psel, penable, rsp_valid, busy, cmd_ready}),
            64'({(n >= 1 && n < done), (n >= 2 && n < done), (n >= done), 1'b1, 1'b0}));
      check("apb_bus", 64'({paddr, pwrite, pwdata}), 64'({exp_paddr, exp_pwrite, exp_pwdata}));
      if (n >= done)
        check("rsp", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'({v.x_rdata, v.x_err, v.x_to}));
      if (v.div == 0) pclken = 1'($urandom);
      else            pclken = ((cyc % v.div) == v.div - 1);
      if (pclken && n >= 2 && n < done) begin
        pready  = (n - 2 >= v.waits);
        prdata  = pready ? v.rd : $urandom;
        pslverr = pready ? v.se : 1'($urandom);
      end else begin
        pready  = 1'($urandom);
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end
      cmd_valid = 1'b1;
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = $urandom;
      if (n >= done) begin
        rsp_ready = (held >= v.hold);
        held++;
      end else begin
        rsp_ready = 1'($urandom);
      end
      if (n >= done && rsp_ready) begin
        cmd_valid = 1'b0;
        finished  = 1;
      end
      @(posedge clk); #1;
      if (pclken && n < done) n++;
    end
    check("cycle_bound", 64'(finished), 64'(1));
    check("idle_ctrl", 64'({psel, penable, rsp_valid, busy, cmd_ready}), 64'(5'b00001));
    check("idle_bus", 64'({paddr, pwrite, pwdata}), 64'({exp_paddr, exp_pwrite, exp_pwdata}));
  endtask

  initial begin
    vec_t v;
    //            wr    addr      wdata         rdata        se   wt  dv  hd  x_rdata      x_err x_to
    vecs[0] = '{1'b1, 13'h040, 32'hDEADBEEF, 32'h0BAD0BAD, 1'b0, 0,  1, 0, 32'h00000000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 13'h104, 32'h11111111, 32'h12345678, 1'b0, 3,  1, 1, 32'h12345678, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 13'h000, 32'h22222222, 32'hCAFEF00D, 1'b0, 0,  4, 0, 32'hCAFEF00D, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 13'h200, 32'h33333333, 32'h44444444, 1'b0, 99, 1, 0, 32'h00000000, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 13'h3C0, 32'h55AA55AA, 32'h66666666, 1'b1, 0,  1, 5, 32'h00000000, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 13'h0FF, 32'h77777777, 32'hA5A5A5A5, 1'b1, 2,  2, 2, 32'hA5A5A5A5, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 13'h1FFE, 32'h01020304, 32'h88888888, 1'b0, 7, 1, 0, 32'h00000000, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 13'h0A8, 32'h99999999, 32'hBBBBBBBB, 1'b0, 8,  3, 1, 32'h00000000, 1'b1, 1'b1};

    reset = 1'b1; pclken = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b0; prdata = '0; pslverr = 1'b0; pready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({psel, penable, rsp_valid, busy, cmd_ready}), 64'(5'b00001));
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_bus", 64'({paddr, pwrite, pwdata}), 64'(0));
    check("reset_rsp", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'(0));

    for (int i = 0; i < NVEC; i++) run_xfer(i, vecs[i]);

    // Reset while the access is stalled in ACCESS: bus must drop without waiting for clk
    $display("xfer %0d: RD addr=0x0ff reset during ACCESS", NVEC);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h0FF; pclken = 1'b1; pready = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_ctrl", 64'({psel, penable, busy}), 64'(3'b111));
    check("pre_reset_paddr", 64'(paddr), 64'(13'h0FC));
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_reset", 64'({psel, penable, busy, rsp_valid}), 64'(4'b0000));
    @(posedge clk); #1;
    reset = 1'b0;
    exp_paddr = '0; exp_pwrite = 1'b0; exp_pwdata = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("post_reset_ctrl", 64'({psel, penable, rsp_valid, busy, cmd_ready}), 64'(5'b00001));
    end
    check("post_reset_bus", 64'({paddr, pwrite, pwdata}), 64'(0));

    for (int i = 0; i < NRAND; i++) begin
      v.wr   = 1'($urandom);
      v.addr = AW'($urandom);
      v.wd   = $urandom;
      v.rd   = $urandom;
      v.se   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       v.waits = TO - 1;
        1:       v.waits = TO;
        2:       v.waits = TO + 3;
        default: v.waits = int'($urandom_range(0, 3));
      endcase
      v.div  = int'($urandom_range(0, 4));
      v.hold = int'($urandom_range(0, 3));
      ref_rsp(v, v.x_rdata, v.x_err, v.x_to);
      run_xfer(NVEC + 1 + i, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
